// File: rtl/curve25519_pkg.sv
// Shared field constants, FSM state type and the p = 2^255-19 reduction helper.
package curve25519_pkg;

  localparam int N = 255;

  // p = 2^255 - 19, written as all-ones minus 18 to avoid a 64-digit literal
  localparam logic [N-1:0] P               = {N{1'b1}} - N'(18);
  localparam logic [N-1:0] P_MINUS_2       = P - N'(2);
  localparam logic [N-1:0] P_MINUS_5_DIV_8 = (P - N'(5)) >> 3;

  // 2^255 == 19 (mod p), the constant used to fold high product bits back down
  localparam int FOLD_K = 19;

  typedef enum logic [2:0] {
    IDLE,
    SQ_ISSUE,
    SQ_WAIT,
    MU_ISSUE,
    MU_WAIT,
    FIN
  } inv_state_t;

  // Reduce a full 510-bit product to canonical form (< p).
  // First fold leaves < 20*2^255; second fold leaves < 2^255 + 361,
  // so a single conditional subtraction of p is enough.
  function automatic logic [N-1:0] fold_reduce(input logic [2*N-1:0] v);
    logic [N+4:0] s1;
    logic [N:0]   s2;
    s1 = {5'd0, v[N-1:0]} + (N+5)'(v[2*N-1:N]) * (N+5)'(FOLD_K);
    s2 = {1'b0, s1[N-1:0]} + (N+1)'(s1[N+4:N]) * (N+1)'(FOLD_K);
    if (s2 >= {1'b0, P}) begin
      s2 = s2 - {1'b0, P};
    end
    return s2[N-1:0];
  endfunction

endpackage

// File: rtl/mult_modp.sv
// Pipelined modular multiplier over GF(2^255-19).
// rst_n is a synchronous restart; operands must stay stable while en is high
// until data_rdy rises. prod is canonical (< p) even for operands >= p.
module mult_modp
  import curve25519_pkg::*;
(
  input  logic         clk,
  input  logic         en,
  input  logic         rst_n,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] prod,
  output logic         data_rdy
);

  logic [2*N-1:0] w_full;
  logic [2*N-1:0] r_full;
  logic           r_fullValid;
  logic [N-1:0]   r_prod;
  logic           r_rdy;

  assign w_full   = {{N{1'b0}}, x} * {{N{1'b0}}, y};
  assign prod     = r_prod;
  assign data_rdy = r_rdy;

  // Two-stage pipe: register the raw product, then the folded/reduced value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full      <= '0;
      r_fullValid <= 1'b0;
      r_prod      <= '0;
      r_rdy       <= 1'b0;
    end else if (en) begin
      r_full      <= w_full;
      r_fullValid <= 1'b1;
      r_prod      <= fold_reduce(r_full);
      r_rdy       <= r_fullValid;
    end
  end

endmodule

// File: rtl/inv_modp.sv
// Modular inverse / fixed power x^EXP mod p by left-to-right square-and-multiply.
// Sequences one mult_modp: each operation is an issue cycle (restart + operands)
// followed by wait cycles until the multiplier reports data_rdy.
module inv_modp #(
  parameter int           N   = 255,
  parameter logic [N-1:0] EXP = curve25519_pkg::P_MINUS_2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  import curve25519_pkg::*;

  // The top exponent bit is consumed by loading acc with x, so the scan starts one below
  localparam logic [7:0] BIT_START = 8'(N - 2);

  inv_state_t   r_state;
  inv_state_t   w_nextState;
  logic [N-1:0] r_acc;
  logic [N-1:0] r_base;
  logic [N-1:0] r_result;
  logic [7:0]   r_bitIdx;

  logic         w_issue;
  logic         w_multEn;
  logic         w_multRstN;
  logic [N-1:0] w_multY;
  logic [N-1:0] w_prod;
  logic         w_dataRdy;
  logic         w_expBit;
  logic         w_lastBit;

  assign w_expBit   = EXP[r_bitIdx];
  assign w_lastBit  = (r_bitIdx == 8'd0);
  assign w_multRstN = ~rst & ~w_issue;
  assign result     = r_result;

  mult_modp u_mult (
    .clk      (clk),
    .en       (w_multEn),
    .rst_n    (w_multRstN),
    .x        (r_acc),
    .y        (w_multY),
    .prod     (w_prod),
    .data_rdy (w_dataRdy)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus multiplier controls and status outputs
  always_comb begin
    w_nextState = r_state;
    w_issue     = 1'b0;
    w_multEn    = 1'b0;
    w_multY     = r_acc;
    busy        = (r_state != IDLE);
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = SQ_ISSUE;
        end
      end
      SQ_ISSUE: begin
        w_issue     = 1'b1;
        w_multEn    = 1'b1;
        w_nextState = SQ_WAIT;
      end
      SQ_WAIT: begin
        w_multEn = 1'b1;
        if (w_dataRdy) begin
          if (w_expBit) begin
            w_nextState = MU_ISSUE;
          end else if (w_lastBit) begin
            w_nextState = FIN;
          end else begin
            w_nextState = SQ_ISSUE;
          end
        end
      end
      MU_ISSUE: begin
        w_issue     = 1'b1;
        w_multEn    = 1'b1;
        w_multY     = r_base;
        w_nextState = MU_WAIT;
      end
      MU_WAIT: begin
        w_multEn = 1'b1;
        w_multY  = r_base;
        if (w_dataRdy) begin
          w_nextState = w_lastBit ? FIN : SQ_ISSUE;
        end
      end
      FIN: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: capture base on accept, fold each product into acc, step the bit index
  // after the bit's optional multiply, and publish the final product as result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_base   <= '0;
      r_result <= '0;
      r_bitIdx <= BIT_START;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_acc    <= x;
            r_base   <= x;
            r_bitIdx <= BIT_START;
          end
        end
        SQ_WAIT: begin
          if (w_dataRdy) begin
            r_acc <= w_prod;
            if (!w_expBit) begin
              if (w_lastBit) begin
                r_result <= w_prod;
              end else begin
                r_bitIdx <= r_bitIdx - 8'd1;
              end
            end
          end
        end
        MU_WAIT: begin
          if (w_dataRdy) begin
            r_acc <= w_prod;
            if (w_lastBit) begin
              r_result <= w_prod;
            end else begin
              r_bitIdx <= r_bitIdx - 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_modp.sv
// Self-checking bench for inv_modp with the default exponent p-2.
module tb_inv_modp;

  localparam int           N         = 255;
  localparam logic [N-1:0] P         = {N{1'b1}} - N'(18);
  localparam int           RUN_LIMIT = 8000;
  localparam int           NUM_VEC   = 7;
  localparam int           NUM_RAND  = 8;

  typedef struct {
    string        name;
    logic [N-1:0] x;
    logic [N-1:0] expected;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] x;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  int checkCount = 0;
  int errorCount = 0;
  int baseCycles = 0;

  vec_t vecs [NUM_VEC];

  always #5 clk = ~clk;

  inv_modp dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x      (x),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Reference modular product using plain wide arithmetic
  function automatic logic [N-1:0] modMul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N+1:0] full;
    logic [2*N+1:0] m;
    full = {{(N+2){1'b0}}, a} * {{(N+2){1'b0}}, b};
    m    = full % {{(N+2){1'b0}}, P};
    return m[N-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [N:0] actual, input logic [N:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic finishBench();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  endtask

  // Pulse start for one cycle from a negedge; x is scrambled afterwards to prove it was sampled
  task automatic applyStimulus(input logic [N-1:0] xin);
    start = 1'b1;
    x     = xin;
    @(negedge clk);
    start = 1'b0;
    x     = ~xin;
  endtask

  task automatic waitDone(input string name, inout int cycles);
    while (done !== 1'b1) begin
      if (cycles >= RUN_LIMIT) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL %s timeout: done=%b after %0d cycles, expected done=1", name, done, cycles);
        finishBench();
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  // One full run: cycles counts the start cycle through the done cycle inclusive
  task automatic runInversion(input string name, input logic [N-1:0] xin,
                              output logic [N-1:0] res, output int cycles);
    applyStimulus(xin);
    cycles = 2;
    checkOutput({name, " busy"}, (N+1)'(busy), (N+1)'(1));
    waitDone(name, cycles);
    res = result;
    @(negedge clk);
    checkOutput({name, " done single"}, (N+1)'(done), (N+1)'(0));
    checkOutput({name, " busy after"}, (N+1)'(busy), (N+1)'(0));
  endtask

  initial begin
    logic [N-1:0] res;
    logic [N-1:0] r;
    logic [N+1:0] t3;
    int           cycles;

    vecs[0] = '{"x=1",   N'(1),        N'(1)};
    vecs[1] = '{"x=0",   N'(0),        N'(0)};
    vecs[2] = '{"x=2",   N'(2),        (P + N'(1)) >> 1};
    vecs[3] = '{"x=p-1", P - N'(1),    P - N'(1)};
    vecs[4] = '{"x=5",   N'(5),        (P + N'(1)) / N'(5)};
    vecs[5] = '{"x=p",   P,            N'(0)};
    vecs[6] = '{"x=p+1", P + N'(1),    N'(1)};

    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy",   (N+1)'(busy),   (N+1)'(0));
    checkOutput("reset done",   (N+1)'(done),   (N+1)'(0));
    checkOutput("reset result", (N+1)'(result), (N+1)'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NUM_VEC; i++) begin
      runInversion(vecs[i].name, vecs[i].x, res, cycles);
      checkOutput({vecs[i].name, " result"}, (N+1)'(res), (N+1)'(vecs[i].expected));
      if (i == 0) begin
        baseCycles = cycles;
        checkOutput("baseline op structure (cycles-2)%506", (N+1)'((cycles - 2) % 506), (N+1)'(0));
      end else begin
        checkOutput({vecs[i].name, " cycles"}, (N+1)'(cycles), (N+1)'(baseCycles));
      end
      if (vecs[i].expected != '0) begin
        checkOutput({vecs[i].name, " x*r"}, (N+1)'(modMul(vecs[i].x, res)), (N+1)'(1));
      end
    end

    for (int k = 0; k < NUM_RAND; k++) begin
      r = N'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      if (modMul(r, N'(1)) == '0) begin
        r = N'(7);
      end
      runInversion("random", r, res, cycles);
      checkOutput("random x*r", (N+1)'(modMul(r, res)), (N+1)'(1));
      checkOutput("random cycles", (N+1)'(cycles), (N+1)'(baseCycles));
    end

    // start re-pulsed mid-run with another x, and again in the done cycle
    applyStimulus(N'(7));
    cycles = 2;
    repeat (10) begin
      @(negedge clk);
      cycles++;
    end
    start = 1'b1;
    x     = N'(11);
    @(negedge clk);
    cycles++;
    start = 1'b0;
    x     = '0;
    waitDone("repulse", cycles);
    res   = result;
    start = 1'b1;
    x     = N'(13);
    checkOutput("repulse cycles", (N+1)'(cycles), (N+1)'(baseCycles));
    checkOutput("repulse x7*r", (N+1)'(modMul(N'(7), res)), (N+1)'(1));
    @(negedge clk);
    checkOutput("start at done ignored busy", (N+1)'(busy), (N+1)'(0));
    checkOutput("start at done ignored done", (N+1)'(done), (N+1)'(0));
    @(negedge clk);
    start  = 1'b0;
    x      = '0;
    cycles = 2;
    checkOutput("accept after done busy", (N+1)'(busy), (N+1)'(1));
    waitDone("after done", cycles);
    checkOutput("after done x13*r", (N+1)'(modMul(N'(13), result)), (N+1)'(1));
    checkOutput("after done cycles", (N+1)'(cycles), (N+1)'(baseCycles));
    @(negedge clk);

    // reset asserted around the midpoint of a run
    applyStimulus(N'(9));
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid reset busy",   (N+1)'(busy),   (N+1)'(0));
    checkOutput("mid reset done",   (N+1)'(done),   (N+1)'(0));
    checkOutput("mid reset result", (N+1)'(result), (N+1)'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("post reset busy",   (N+1)'(busy),   (N+1)'(0));
    checkOutput("post reset result", (N+1)'(result), (N+1)'(0));

    // fresh start after the abort: inverse of 3 is (2p+1)/3
    t3 = (({2'b00, P} << 1) + (N+2)'(1)) / (N+2)'(3);
    runInversion("x=3", N'(3), res, cycles);
    checkOutput("x=3 result", (N+1)'(res), (N+1)'(t3[N-1:0]));
    checkOutput("x=3 x*r", (N+1)'(modMul(N'(3), res)), (N+1)'(1));
    checkOutput("x=3 cycles", (N+1)'(cycles), (N+1)'(baseCycles));

    finishBench();
  end

endmodule
